// File: rtl/spi_arb2.sv
// Two-requester round-robin arbiter/sequencer in front of a single 16-bit SPI master.
// Optional watchdog abort of a stuck frame is enabled by defining SPI_ARB_WDOG_EN.
module spi_arb2 #(
    parameter int GAP_CYC  = 4,
    parameter int WDOG_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic [15:0] cmd0,
    output logic        busy0,
    output logic        done0,
    input  logic        wrt1,
    input  logic [15:0] cmd1,
    output logic        busy1,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        ovf,
    output logic        err,
    output logic        m_wrt,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [15:0] m_rd_data
);

    // One counter serves both the post-frame gap and the WAIT watchdog.
    localparam int CNT_MAX = (GAP_CYC > WDOG_CYC) ? GAP_CYC : WDOG_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t           state_reg;
    logic [1:0]       pend_reg;
    logic [15:0]      cmd_reg [2];
    logic             owner_reg;
    logic             last_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [1:0]       wrt_vec;
    logic [1:0]       busy_vec;
    logic [1:0]       pend_set;
    logic [1:0]       pend_clr;
    logic [15:0]      cmd_in [2];
    logic             launch_go;
    logic             grant_sel;

    assign wrt_vec   = {wrt1, wrt0};
    assign cmd_in[0] = cmd0;
    assign cmd_in[1] = cmd1;
    assign busy0     = busy_vec[0];
    assign busy1     = busy_vec[1];
    assign launch_go = (state_reg == IDLE) && (|pend_reg);

    // last_reg holds the most recent grant; on contention the other side wins.
    always_comb begin
        grant_sel = pend_reg[1];
        if (&pend_reg) begin
            grant_sel = ~last_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign busy_vec[gi] = pend_reg[gi] |
                                  (((state_reg == LAUNCH) || (state_reg == WAIT)) &&
                                   (owner_reg == 1'(gi)));
            assign pend_set[gi] = wrt_vec[gi] & ~busy_vec[gi];
            assign pend_clr[gi] = launch_go && (grant_sel == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cmd_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pend_set[i]) begin
                    cmd_reg[i] <= cmd_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
            m_wrt     <= 1'b0;
            m_cmd     <= '0;
            rd_data   <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            ovf       <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
            err       <= 1'b0;
`endif
        end else begin
            pend_reg <= (pend_reg | pend_set) & ~pend_clr;
            ovf      <= |(wrt_vec & busy_vec);
            m_wrt    <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
            err      <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (launch_go) begin
                        owner_reg <= grant_sel;
                        last_reg  <= grant_sel;
                        m_cmd     <= cmd_reg[grant_sel];
                        m_wrt     <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        rd_data   <= m_rd_data;
                        done0     <= ~owner_reg;
                        done1     <= owner_reg;
                        cnt_reg   <= CNT_W'(GAP_CYC);
                        state_reg <= (GAP_CYC == 0) ? IDLE : GAP;
                    end
`ifdef SPI_ARB_WDOG_EN
                    // The LAUNCH cycle counts toward the budget, hence the -2.
                    else if (cnt_reg == CNT_W'(WDOG_CYC - 2)) begin
                        rd_data   <= 16'hDEAD;
                        err       <= 1'b1;
                        done0     <= ~owner_reg;
                        done1     <= owner_reg;
                        cnt_reg   <= CNT_W'(GAP_CYC);
                        state_reg <= (GAP_CYC == 0) ? IDLE : GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
`endif
                end
                GAP: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifndef SPI_ARB_WDOG_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb2.sv
// Self-checking bench for spi_arb2: directed scenarios plus randomized traffic
// against a timestamp-based reference model of the arbitration rules.
module tb_spi_arb2;

    localparam int GAP  = 4;
    localparam int WDOG = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrt0, wrt1;
    logic [15:0] cmd0, cmd1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] rd_data;
    logic        ovf, err, m_wrt;
    logic [15:0] m_cmd;
    logic        m_done;
    logic [15:0] m_rd_data;

    spi_arb2 #(.GAP_CYC(GAP), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .cmd0(cmd0), .busy0(busy0), .done0(done0),
        .wrt1(wrt1), .cmd1(cmd1), .busy1(busy1), .done1(done1),
        .rd_data(rd_data), .ovf(ovf), .err(err),
        .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [15:0] cmd; int cyc; } launch_t;
    typedef struct { logic d0; logic d1; logic er; logic [15:0] rd; int cyc; } done_t;
    launch_t obs_l[$];
    done_t   obs_d[$];
    int      mdone_log[$];
    int      ovf_cnt;

    // Reference model: pending requests, in-flight frame and event timestamps.
    int          mc;
    bit [1:0]    m_pend;
    logic [15:0] m_pcmd [2];
    bit          m_act, m_own, m_last;
    int          m_launch_cyc, m_done_cyc, m_ready;
    bit          m_done_own, m_done_err, m_ovf;
    logic [15:0] m_rd, m_rd_new, m_mcmd, m_mcmd_new;

    // SPI master stand-in.
    int          mdone_cyc;
    logic [15:0] mdone_data;
    int          dly_min, dly_max;
    bit          fixed_en, no_resp, spur_en, force_mdone;
    logic [15:0] fixed_data;

    task automatic apply_reset();
        rst_n = 1'b0;
        wrt0 = 1'b0; wrt1 = 1'b0; cmd0 = '0; cmd1 = '0;
        m_done = 1'b0; m_rd_data = '0; force_mdone = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mc = 0; m_pend = '0; m_pcmd[0] = '0; m_pcmd[1] = '0;
        m_act = 0; m_own = 0; m_last = 1;
        m_launch_cyc = -100; m_done_cyc = -100; m_ready = 0;
        m_done_own = 0; m_done_err = 0; m_ovf = 0;
        m_rd = '0; m_rd_new = '0; m_mcmd = '0; m_mcmd_new = '0;
        mdone_cyc = -1; mdone_data = '0;
        obs_l.delete(); obs_d.delete(); mdone_log.delete(); ovf_cnt = 0;
    endtask

    // One clock cycle: drive master, compare DUT to model mid-cycle, advance model.
    task automatic tick();
        bit          sched;
        bit   [1:0]  e_busy;
        logic [6:0]  e_ctl, a_ctl;
        bit   [1:0]  w;
        logic [15:0] c [2];
        bit          sel;
        launch_t     lt;
        done_t       dt;
        sched = (mc == mdone_cyc);
        m_done = sched | force_mdone | (spur_en && !m_act && ($urandom_range(0, 7) == 0));
        m_rd_data = sched ? mdone_data : 16'($urandom);
        if (sched) mdone_log.push_back(mc);
        force_mdone = 1'b0;
        @(negedge clk);
        if (mc == m_done_cyc) m_rd = m_rd_new;
        if (mc == m_launch_cyc) m_mcmd = m_mcmd_new;
        e_busy[0] = m_pend[0] | (m_act & (m_own == 1'b0));
        e_busy[1] = m_pend[1] | (m_act & (m_own == 1'b1));
        e_ctl = {e_busy[1], e_busy[0],
                 (mc == m_done_cyc) && m_done_own, (mc == m_done_cyc) && !m_done_own,
                 m_ovf, (mc == m_done_cyc) && m_done_err, mc == m_launch_cyc};
        a_ctl = {busy1, busy0, done1, done0, ovf, err, m_wrt};
        checks++;
        if (a_ctl !== e_ctl) begin
            errors++;
            $display("FAIL ctl cyc=%0d {busy1,busy0,done1,done0,ovf,err,m_wrt} got=%b exp=%b", mc, a_ctl, e_ctl);
        end
        checks++;
        if (rd_data !== m_rd) begin
            errors++;
            $display("FAIL rd_data cyc=%0d got=%h exp=%h", mc, rd_data, m_rd);
        end
        checks++;
        if (m_cmd !== m_mcmd) begin
            errors++;
            $display("FAIL m_cmd cyc=%0d got=%h exp=%h", mc, m_cmd, m_mcmd);
        end
        if (m_wrt === 1'b1) begin
            lt.cmd = m_cmd; lt.cyc = mc;
            obs_l.push_back(lt);
        end
        if ((done0 | done1) === 1'b1) begin
            dt.d0 = done0; dt.d1 = done1; dt.er = err; dt.rd = rd_data; dt.cyc = mc;
            obs_d.push_back(dt);
            $display("txn done0=%b done1=%b err=%b rd_data=%h cyc=%0d", done0, done1, err, rd_data, mc);
        end
        if (ovf === 1'b1) ovf_cnt++;

        w = {wrt1, wrt0};
        c[0] = cmd0; c[1] = cmd1;
        if (!m_act && mc >= m_ready && (m_pend != 2'b00)) begin
            sel = (m_pend == 2'b11) ? !m_last : m_pend[1];
            m_last = sel; m_own = sel; m_act = 1;
            m_launch_cyc = mc + 1;
            m_mcmd_new = m_pcmd[sel];
            m_pend[sel] = 1'b0;
            if (!no_resp) begin
                mdone_cyc  = m_launch_cyc + $urandom_range(dly_min, dly_max);
                mdone_data = fixed_en ? fixed_data : 16'($urandom);
            end else begin
                mdone_cyc = -1;
            end
        end else if (m_act && mc > m_launch_cyc && m_done) begin
            m_act = 0; m_done_cyc = mc + 1; m_done_own = m_own; m_done_err = 0;
            m_rd_new = m_rd_data; m_ready = mc + 1 + GAP;
        end
`ifdef SPI_ARB_WDOG_EN
        else if (m_act && mc == m_launch_cyc + WDOG - 1) begin
            m_act = 0; m_done_cyc = mc + 1; m_done_own = m_own; m_done_err = 1;
            m_rd_new = 16'hDEAD; m_ready = mc + 1 + GAP;
        end
`endif
        m_ovf = 0;
        for (int r = 0; r < 2; r++) begin
            if (w[r]) begin
                if (e_busy[r]) m_ovf = 1;
                else begin
                    m_pend[r] = 1'b1;
                    m_pcmd[r] = c[r];
                end
            end
        end
        @(posedge clk);
        #1;
        wrt0 = 1'b0; wrt1 = 1'b0; m_done = 1'b0;
        mc++;
    endtask

    task automatic set_master(input int lo, input int hi);
        dly_min = lo; dly_max = hi; fixed_en = 0; no_resp = 0; spur_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wrt0 = 1'b0; wrt1 = 1'b0; cmd0 = '0; cmd1 = '0; m_done = 1'b0; m_rd_data = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy0, busy1, done0, done1, ovf, err, m_wrt} !== 7'b0 || rd_data !== 16'h0 || m_cmd !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b rd=%h mcmd=%h exp all zero",
                     {busy0, busy1, done0, done1, ovf, err, m_wrt}, rd_data, m_cmd);
        end
        apply_reset();
        set_master(1, 4);
        repeat (5) tick();
    endtask

    task automatic test_single();
        apply_reset();
        set_master(3, 3);
        fixed_en = 1; fixed_data = 16'h00A5;
        while (mc < 10) tick();
        wrt0 = 1'b1; cmd0 = 16'h8F00;
        tick();
        for (int i = 0; i < 40 && obs_d.size() < 1; i++) tick();
        repeat (3) tick();
        checks++;
        if (obs_l.size() != 1 || obs_d.size() != 1 || mdone_log.size() != 1) begin
            errors++;
            $display("FAIL single_count launches=%0d dones=%0d exp 1 and 1", obs_l.size(), obs_d.size());
        end else begin
            checks++;
            if (obs_l[0].cyc != 12 || obs_l[0].cmd !== 16'h8F00) begin
                errors++;
                $display("FAIL single_launch got cyc=%0d cmd=%h exp cyc=12 cmd=8f00", obs_l[0].cyc, obs_l[0].cmd);
            end
            checks++;
            if (obs_d[0].cyc != mdone_log[0] + 1 || obs_d[0].d0 !== 1'b1 || obs_d[0].d1 !== 1'b0 ||
                obs_d[0].rd !== 16'h00A5) begin
                errors++;
                $display("FAIL single_done got cyc=%0d d0=%b d1=%b rd=%h exp cyc=%0d d0=1 d1=0 rd=00a5",
                         obs_d[0].cyc, obs_d[0].d0, obs_d[0].d1, obs_d[0].rd, mdone_log[0] + 1);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        set_master(2, 5);
        repeat (2) tick();
        wrt0 = 1'b1; cmd0 = 16'h1111;
        wrt1 = 1'b1; cmd1 = 16'h2222;
        tick();
        for (int i = 0; i < 100 && obs_d.size() < 2; i++) tick();
        checks++;
        if (obs_l.size() != 2 || mdone_log.size() < 1) begin
            errors++;
            $display("FAIL simul_count launches=%0d exp 2", obs_l.size());
        end else begin
            checks++;
            if (obs_l[0].cmd !== 16'h1111 || obs_l[1].cmd !== 16'h2222) begin
                errors++;
                $display("FAIL simul_order got %h,%h exp 1111,2222", obs_l[0].cmd, obs_l[1].cmd);
            end
            checks++;
            if (obs_l[1].cyc - mdone_log[0] < GAP + 2) begin
                errors++;
                $display("FAIL simul_gap got %0d cycles exp >= %0d", obs_l[1].cyc - mdone_log[0], GAP + 2);
            end
        end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_cmd [4];
        int k0, k1;
        exp_cmd[0] = 16'hA000; exp_cmd[1] = 16'hB000; exp_cmd[2] = 16'hA001; exp_cmd[3] = 16'hB001;
        apply_reset();
        set_master(1, 6);
        repeat (2) tick();
        wrt0 = 1'b1; cmd0 = 16'hA000; k0 = 1;
        tick();
        wrt1 = 1'b1; cmd1 = 16'hB000; k1 = 1;
        tick();
        for (int i = 0; i < 400 && obs_l.size() < 4; i++) begin
            if (done0 === 1'b1 && k0 < 3) begin
                wrt0 = 1'b1; cmd0 = 16'hA000 + 16'(k0); k0++;
            end
            if (done1 === 1'b1 && k1 < 3) begin
                wrt1 = 1'b1; cmd1 = 16'hB000 + 16'(k1); k1++;
            end
            tick();
        end
        checks++;
        if (obs_l.size() < 4) begin
            errors++;
            $display("FAIL fair_timeout launches=%0d exp 4", obs_l.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs_l[j].cmd !== exp_cmd[j]) begin
                    errors++;
                    $display("FAIL fair_order idx=%0d got=%h exp=%h", j, obs_l[j].cmd, exp_cmd[j]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        set_master(4, 6);
        repeat (2) tick();
        wrt1 = 1'b1; cmd1 = 16'hC0DE;
        tick();
        wrt1 = 1'b1; cmd1 = 16'hBAD1;
        tick();
        tick();
        wrt1 = 1'b1; cmd1 = 16'hBAD2;
        tick();
        for (int i = 0; i < 60 && obs_d.size() < 1; i++) tick();
        repeat (15) tick();
        checks++;
        if (ovf_cnt != 2) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=2", ovf_cnt);
        end
        checks++;
        if (obs_l.size() != 1 || obs_d.size() != 1) begin
            errors++;
            $display("FAIL ovf_launches got launches=%0d dones=%0d exp 1 and 1", obs_l.size(), obs_d.size());
        end else begin
            checks++;
            if (obs_l[0].cmd !== 16'hC0DE || obs_d[0].d1 !== 1'b1) begin
                errors++;
                $display("FAIL ovf_cmd got cmd=%h d1=%b exp cmd=c0de d1=1", obs_l[0].cmd, obs_d[0].d1);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_master(1, 1);
        no_resp = 1;
        repeat (2) tick();
        wrt0 = 1'b1; cmd0 = 16'h1234;
        wrt1 = 1'b1; cmd1 = 16'h5678;
        tick();
        for (int i = 0; i < 20 && obs_l.size() < 1; i++) tick();
        repeat (2) tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy0, busy1, done0, done1, ovf, err, m_wrt} !== 7'b0 || rd_data !== 16'h0 || m_cmd !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs got ctl=%b rd=%h mcmd=%h exp all zero",
                     {busy0, busy1, done0, done1, ovf, err, m_wrt}, rd_data, m_cmd);
        end
        apply_reset();
        no_resp = 0;
        repeat (30) tick();
        checks++;
        if (obs_l.size() != 0 || obs_d.size() != 0) begin
            errors++;
            $display("FAIL midreset_quiet got launches=%0d dones=%0d exp 0 and 0", obs_l.size(), obs_d.size());
        end
        wrt1 = 1'b1; cmd1 = 16'h9999;
        tick();
        for (int i = 0; i < 30 && obs_d.size() < 1; i++) tick();
        checks++;
        if (obs_l.size() != 1 || obs_l[0].cmd !== 16'h9999) begin
            errors++;
            $display("FAIL midreset_new got launches=%0d exp one launch of 9999", obs_l.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        set_master(1, 8);
        spur_en = 1;
        for (int i = 0; i < 2500; i++) begin
            wrt0 = ($urandom_range(0, 3) == 0); cmd0 = 16'($urandom);
            wrt1 = ($urandom_range(0, 3) == 0); cmd1 = 16'($urandom);
            tick();
        end
        spur_en = 0;
        repeat (20) tick();
        checks++;
        if (obs_d.size() < 50) begin
            errors++;
            $display("FAIL random_progress got dones=%0d exp >= 50", obs_d.size());
        end
    endtask

`ifdef SPI_ARB_WDOG_EN
    task automatic test_wdog();
        apply_reset();
        set_master(2, 4);
        no_resp = 1;
        repeat (2) tick();
        wrt0 = 1'b1; cmd0 = 16'h5A5A;
        tick();
        wrt1 = 1'b1; cmd1 = 16'h6B6B;
        tick();
        for (int i = 0; i < 1200 && obs_d.size() < 1; i++) tick();
        force_mdone = 1'b1;
        no_resp = 0;
        for (int i = 0; i < 100 && obs_d.size() < 2; i++) tick();
        checks++;
        if (obs_d.size() < 2 || obs_l.size() < 2) begin
            errors++;
            $display("FAIL wdog_timeout dones=%0d launches=%0d exp 2 and 2", obs_d.size(), obs_l.size());
        end else begin
            checks++;
            if (obs_d[0].cyc - obs_l[0].cyc != WDOG || obs_d[0].er !== 1'b1 || obs_d[0].d0 !== 1'b1 ||
                obs_d[0].rd !== 16'hDEAD) begin
                errors++;
                $display("FAIL wdog_abort got dt=%0d err=%b d0=%b rd=%h exp dt=%0d err=1 d0=1 rd=dead",
                         obs_d[0].cyc - obs_l[0].cyc, obs_d[0].er, obs_d[0].d0, obs_d[0].rd, WDOG);
            end
            checks++;
            if (obs_l[1].cmd !== 16'h6B6B || obs_l[1].cyc != obs_d[0].cyc + GAP + 1) begin
                errors++;
                $display("FAIL wdog_next got cmd=%h cyc=%0d exp cmd=6b6b cyc=%0d",
                         obs_l[1].cmd, obs_l[1].cyc, obs_d[0].cyc + GAP + 1);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        dly_min = 1; dly_max = 1; fixed_en = 0; no_resp = 0; spur_en = 0;
        force_mdone = 0; fixed_data = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overflow();
        test_reset_mid();
        test_random();
`ifdef SPI_ARB_WDOG_EN
        test_wdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
